jtag_stream_ctrl: RTL and testbench

- Sequencer between the BSCAN USER4 data-register port and the puzzle solver datapath, running entirely in the tck domain.
- Upload phase: each 8-bit DR scan delivers one input byte into a small FIFO, which feeds the solver over a valid/ready stream.
- End of input is detected from the trailing-newline convention, and an end-of-file pulse is issued to the solver.
- Readback phase: the latched solver result is returned on tdo, LSB first, during RESULT_WIDTH-bit DR scans.

---
 rtl/jtag_stream_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_jtag_stream_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_stream_ctrl.sv
// ============================================================================
// jtag_stream_ctrl
// ----------------------------------------------------------------------------
// Purpose:
//   Sequencer between the BSCAN USER4 data-register port and the puzzle
//   solver datapath. All logic runs in the tck domain.
//   * Upload: each 8-bit DR scan writes one byte into a first-word-fall-
//     through FIFO. The FIFO feeds the solver over a valid/ready stream.
//   * End of input: two consecutive pushed 0x0A bytes mark end of input.
//     Once the FIFO drains, the block pulses end_of_file for one cycle.
//   * Readback: after the solver reports a result, Capture-DR loads the
//     latched result. The result then shifts out on tdo, LSB first.
//
// Ports:
//   tck, trst_n          clock; asynchronous active-low reset
//   test_logic_reset     synchronous clear (TAP in Test-Logic-Reset)
//   tdi / tdo            serial in / out (tdo = shift_reg[0])
//   ir_is_user           gates capture_dr / shift_dr / update_dr
//   capture_dr, shift_dr, update_dr   TAP DR state strobes
//   inbound_byte/_valid/_ready        byte stream to the solver
//   end_of_file          one-cycle pulse once all input has been delivered
//   result, result_valid solver answer
//   overflow             sticky: a byte was dropped because the FIFO was full
//   dbg_state            current sequencer state (0 RECEIVE, 1 DRAIN,
//                        2 SOLVE, 3 DONE)
//
// Stream handshake: a byte transfers on every tck edge where inbound_valid
// and inbound_ready are both high. inbound_valid never depends on
// inbound_ready. inbound_byte stays stable while inbound_valid is high and
// no transfer has occurred.
// ============================================================================
module jtag_stream_ctrl #(
    parameter int RESULT_WIDTH = 16,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                    tck,
    input  logic                    trst_n,
    input  logic                    tdi,
    output logic                    tdo,
    input  logic                    test_logic_reset,
    input  logic                    ir_is_user,
    input  logic                    capture_dr,
    input  logic                    shift_dr,
    input  logic                    update_dr,
    output logic [7:0]              inbound_byte,
    output logic                    inbound_valid,
    input  logic                    inbound_ready,
    output logic                    end_of_file,
    input  logic [RESULT_WIDTH-1:0] result,
    input  logic                    result_valid,
    output logic                    overflow,
    output logic [1:0]              dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_RECEIVE = 2'd0,
        S_DRAIN   = 2'd1,
        S_SOLVE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [RESULT_WIDTH-1:0] r_shift;
    logic [RESULT_WIDTH-1:0] r_result;
    logic [7:0]              r_mem [FIFO_DEPTH];
    logic [AW:0]             r_wr_ptr;
    logic [AW:0]             r_rd_ptr;
    logic                    r_last_was_lf;
    logic                    r_overflow;

    logic                    w_capture;
    logic                    w_shift;
    logic                    w_update;
    logic [7:0]              w_byte;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_pop;
    logic                    w_write;
    logic                    w_push;
    logic                    w_drop;
    logic                    w_byte_is_lf;
    logic                    w_end_seen;

    // ------------------------------------------------------------------
    // DR strobes only count while the IR selects USER4
    // ------------------------------------------------------------------
    assign w_capture = ir_is_user & capture_dr;
    assign w_shift   = ir_is_user & shift_dr;
    assign w_update  = ir_is_user & update_dr;

    // Bits shift in LSB first from the top, so the last 8 bits shifted
    // sit in the top byte of the register.
    assign w_byte       = r_shift[RESULT_WIDTH-1 -: 8];
    assign w_byte_is_lf = (w_byte == 8'h0A);

    // ------------------------------------------------------------------
    // FIFO status. The extra pointer bit separates full from empty.
    // ------------------------------------------------------------------
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_pop   = ~w_empty & inbound_ready;
    assign w_write = w_update & (r_state == S_RECEIVE);
    // A pop in the same cycle frees the slot the write lands in. When the
    // FIFO is full, the write slot is the head entry being read this cycle.
    assign w_push  = w_write & (~w_full | w_pop);
    assign w_drop  = w_write & ~w_push;

    // Two consecutive pushed LFs end the input. Dropped bytes do not count.
    assign w_end_seen = w_push & w_byte_is_lf & r_last_was_lf;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_state <= S_RECEIVE;
        end else if (test_logic_reset) begin
            r_state <= S_RECEIVE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RECEIVE: if (w_end_seen)   w_next_state = S_DRAIN;
            // No pushes happen outside RECEIVE. Once the FIFO is empty,
            // every byte has been delivered.
            S_DRAIN:   if (w_empty)      w_next_state = S_SOLVE;
            S_SOLVE:   if (result_valid) w_next_state = S_DONE;
            S_DONE:                      w_next_state = S_DONE;
            default:                     w_next_state = S_RECEIVE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        end_of_file = 1'b0;
        dbg_state   = r_state;
        // DRAIN lasts exactly one cycle once the FIFO is empty, so this
        // is a single-cycle pulse.
        if (r_state == S_DRAIN && w_empty) begin
            end_of_file = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // DR shift register
    // ------------------------------------------------------------------
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_shift <= '0;
        end else if (test_logic_reset) begin
            r_shift <= '0;
        end else if (w_capture) begin
            // The host polls until it reads a nonzero value.
            r_shift <= (r_state == S_DONE) ? r_result : '0;
        end else if (w_shift) begin
            r_shift <= {tdi, r_shift[RESULT_WIDTH-1:1]};
        end
    end

    assign tdo = r_shift[0];

    // ------------------------------------------------------------------
    // Result latch
    // ------------------------------------------------------------------
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_result <= '0;
        end else if (test_logic_reset) begin
            r_result <= '0;
        end else if (r_state == S_SOLVE && result_valid) begin
            r_result <= result;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage and pointers. The storage needs no reset; clearing the
    // pointers empties the FIFO.
    // ------------------------------------------------------------------
    always_ff @(posedge tck) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_byte;
        end
    end

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (test_logic_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            if (w_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // The head entry is a register, so a push appears at the output
    // on the cycle after the write.
    assign inbound_byte  = r_mem[r_rd_ptr[AW-1:0]];
    assign inbound_valid = ~w_empty;

    // ------------------------------------------------------------------
    // LF tracking and sticky overflow
    // ------------------------------------------------------------------
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_last_was_lf <= 1'b0;
            r_overflow    <= 1'b0;
        end else if (test_logic_reset) begin
            r_last_was_lf <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_push) r_last_was_lf <= w_byte_is_lf;
            if (w_drop) r_overflow    <= 1'b1;
        end
    end

    assign overflow = r_overflow;

endmodule

// File: tb/tb_jtag_stream_ctrl.sv
// ============================================================================
// tb_jtag_stream_ctrl
// ----------------------------------------------------------------------------
// Directed bench for jtag_stream_ctrl (RESULT_WIDTH 16, FIFO_DEPTH 16).
// Drives TAP DR scans and the solver handshake from tasks. A negedge
// monitor collects every stream transfer and every end_of_file pulse.
// ============================================================================
module tb_jtag_stream_ctrl;

    localparam int RW = 16;

    // ---------------------------------------------------------------- clock/reset
    logic          tck = 1'b0;
    logic          trst_n;
    logic          tdi;
    logic          tdo;
    logic          test_logic_reset;
    logic          ir_is_user;
    logic          capture_dr;
    logic          shift_dr;
    logic          update_dr;
    logic [7:0]    inbound_byte;
    logic          inbound_valid;
    logic          inbound_ready;
    logic          end_of_file;
    logic [RW-1:0] result;
    logic          result_valid;
    logic          overflow;
    logic [1:0]    dbg_state;

    always #5 tck = ~tck;

    jtag_stream_ctrl #(.RESULT_WIDTH(RW), .FIFO_DEPTH(16)) dut (
        .tck              (tck),
        .trst_n           (trst_n),
        .tdi              (tdi),
        .tdo              (tdo),
        .test_logic_reset (test_logic_reset),
        .ir_is_user       (ir_is_user),
        .capture_dr       (capture_dr),
        .shift_dr         (shift_dr),
        .update_dr        (update_dr),
        .inbound_byte     (inbound_byte),
        .inbound_valid    (inbound_valid),
        .inbound_ready    (inbound_ready),
        .end_of_file      (end_of_file),
        .result           (result),
        .result_valid     (result_valid),
        .overflow         (overflow),
        .dbg_state        (dbg_state)
    );

    // ---------------------------------------------------------------- scoreboard
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         test_cnt = 0;
    int         fail_cnt = 0;
    int         cyc = 0;
    int         last_pop_cyc = 0;
    int         eof_cyc = 0;
    int         eof_cnt = 0;

    // The monitor samples on the negedge, which is away from the active edge.
    always @(negedge tck) begin
        cyc <= cyc + 1;
        if (inbound_valid && inbound_ready) begin
            got_q.push_back(inbound_byte);
            last_pop_cyc <= cyc;
        end
        if (end_of_file) begin
            eof_cnt <= eof_cnt + 1;
            eof_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        test_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------------- driver tasks
    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic do_reset();
        trst_n = 1'b0;
        tick();
        tick();
        trst_n = 1'b1;
        tick();
        got_q.delete();
        exp_q.delete();
    endtask

    // One write scan: capture, 8 shifts LSB first, update. If pop_on_update
    // is set, inbound_ready is raised during the update cycle only.
    task automatic write_byte(input logic [7:0] b, input logic ir, input logic pop_on_update);
        ir_is_user = ir;
        capture_dr = 1'b1;
        tick();
        capture_dr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            shift_dr = 1'b1;
            tdi      = b[i];
            tick();
        end
        shift_dr  = 1'b0;
        tdi       = 1'b0;
        update_dr = 1'b1;
        if (pop_on_update) inbound_ready = 1'b1;
        tick();
        update_dr = 1'b0;
        if (pop_on_update) inbound_ready = 1'b0;
        ir_is_user = 1'b1;
    endtask

    task automatic readback(output logic [RW-1:0] val);
        capture_dr = 1'b1;
        tick();
        capture_dr = 1'b0;
        for (int i = 0; i < RW; i++) begin
            val[i]   = tdo;
            shift_dr = 1'b1;
            tdi      = 1'b0;
            tick();
        end
        shift_dr  = 1'b0;
        update_dr = 1'b1;
        tick();
        update_dr = 1'b0;
    endtask

    task automatic wait_state(input string tag, input logic [1:0] s, input int budget);
        int n = 0;
        while (dbg_state != s && n < budget) begin
            tick();
            n++;
        end
        check(tag, {30'd0, dbg_state}, {30'd0, s});
    endtask

    task automatic wait_empty(input string tag, input int budget);
        int n = 0;
        while (inbound_valid && n < budget) begin
            tick();
            n++;
        end
        check(tag, {31'd0, inbound_valid}, 32'd0);
    endtask

    task automatic compare_stream(input string tag);
        int n = exp_q.size();
        check({tag, "_count"}, got_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (got_q.size() > 0) check(tag, {24'd0, got_q.pop_front()}, {24'd0, exp_q[i]});
        end
        exp_q.delete();
        got_q.delete();
    endtask

    // Upload 0x41 0x0A 0x0A with ready high, then wait for SOLVE.
    task automatic upload_basic(input string tag);
        int eof_before;
        eof_before    = eof_cnt;
        inbound_ready = 1'b1;
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h0A);
        exp_q.push_back(8'h0A);
        write_byte(8'h41, 1'b1, 1'b0);
        check({tag, "_first_valid"}, {31'd0, inbound_valid}, 32'd1);
        check({tag, "_first_byte"}, {24'd0, inbound_byte}, 32'h41);
        check({tag, "_state_recv"}, {30'd0, dbg_state}, 32'd0);
        write_byte(8'h0A, 1'b1, 1'b0);
        write_byte(8'h0A, 1'b1, 1'b0);
        check({tag, "_state_drain"}, {30'd0, dbg_state}, 32'd1);
        wait_state({tag, "_state_solve"}, 2'd2, 20);
        tick();
        check({tag, "_eof_count"}, eof_cnt - eof_before, 32'd1);
        check({tag, "_eof_timing"}, eof_cyc - last_pop_cyc, 32'd1);
        compare_stream({tag, "_stream"});
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        logic [RW-1:0] rb;
        int            eof_before;

        trst_n           = 1'b0;
        tdi              = 1'b0;
        test_logic_reset = 1'b0;
        ir_is_user       = 1'b1;
        capture_dr       = 1'b0;
        shift_dr         = 1'b0;
        update_dr        = 1'b0;
        inbound_ready    = 1'b0;
        result           = '0;
        result_valid     = 1'b0;

        // Reset values
        do_reset();
        check("rst_tdo",      {31'd0, tdo},           32'd0);
        check("rst_valid",    {31'd0, inbound_valid}, 32'd0);
        check("rst_eof",      {31'd0, end_of_file},   32'd0);
        check("rst_overflow", {31'd0, overflow},      32'd0);
        check("rst_state",    {30'd0, dbg_state},     32'd0);

        // A result_valid before SOLVE is ignored.
        result       = 16'hBEEF;
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
        check("early_rv_state", {30'd0, dbg_state}, 32'd0);

        // Basic upload
        upload_basic("t1");

        // Readback before the result is available returns zero.
        readback(rb);
        check("rb_before_result", {16'd0, rb}, 32'h0000);
        check("rb_update_no_push", {31'd0, inbound_valid}, 32'd0);

        result       = 16'h02A7;
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
        result       = 16'h1234;
        check("done_state", {30'd0, dbg_state}, 32'd3);
        readback(rb);
        check("rb_result", {16'd0, rb}, 32'h02A7);
        // DONE holds the latched value; a later result_valid is ignored.
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
        readback(rb);
        check("rb_result_held", {16'd0, rb}, 32'h02A7);

        // Asynchronous reset mid-shift in DONE. tdo shows bit 2 of 0x02A7.
        capture_dr = 1'b1;
        tick();
        capture_dr = 1'b0;
        shift_dr   = 1'b1;
        tick();
        tick();
        check("mid_shift_tdo", {31'd0, tdo}, 32'd1);
        #2;
        trst_n = 1'b0;
        #1;
        check("trst_tdo",   {31'd0, tdo},       32'd0);
        check("trst_state", {30'd0, dbg_state}, 32'd0);
        shift_dr = 1'b0;
        tick();
        trst_n = 1'b1;
        tick();
        got_q.delete();

        // Repeat to DONE, then apply a synchronous Test-Logic-Reset mid-shift.
        upload_basic("t1b");
        result       = 16'h02A7;
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
        capture_dr   = 1'b1;
        tick();
        capture_dr = 1'b0;
        shift_dr   = 1'b1;
        tick();
        tick();
        check("tlr_pre_tdo", {31'd0, tdo}, 32'd1);
        test_logic_reset = 1'b1;
        tick();
        test_logic_reset = 1'b0;
        shift_dr         = 1'b0;
        check("tlr_tdo",   {31'd0, tdo},       32'd0);
        check("tlr_state", {30'd0, dbg_state}, 32'd0);

        // Overflow: 17 writes into a 16-deep FIFO while ready is low.
        do_reset();
        inbound_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            write_byte(8'h10 + 8'(i), 1'b1, 1'b0);
            exp_q.push_back(8'h10 + 8'(i));
        end
        check("ovf_before", {31'd0, overflow}, 32'd0);
        write_byte(8'h77, 1'b1, 1'b0);
        check("ovf_set", {31'd0, overflow}, 32'd1);
        inbound_ready = 1'b1;
        wait_empty("ovf_drain", 40);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        check("ovf_state", {30'd0, dbg_state}, 32'd0);
        compare_stream("ovf_stream");

        // Full FIFO with a same-cycle pop, then the LF sequence.
        do_reset();
        inbound_ready = 1'b0;
        eof_before    = eof_cnt;
        write_byte(8'h0A, 1'b1, 1'b0);
        exp_q.push_back(8'h0A);
        for (int i = 1; i < 16; i++) begin
            write_byte(8'h20 + 8'(i), 1'b1, 1'b0);
            exp_q.push_back(8'h20 + 8'(i));
        end
        write_byte(8'h0A, 1'b1, 1'b1);
        exp_q.push_back(8'h0A);
        check("fullpop_ovf", {31'd0, overflow}, 32'd0);
        check("fullpop_state", {30'd0, dbg_state}, 32'd0);
        inbound_ready = 1'b1;
        write_byte(8'h31, 1'b1, 1'b0);
        exp_q.push_back(8'h31);
        check("lf_31_state", {30'd0, dbg_state}, 32'd0);
        write_byte(8'h0A, 1'b1, 1'b0);
        exp_q.push_back(8'h0A);
        check("lf_single_state", {30'd0, dbg_state}, 32'd0);
        write_byte(8'h0A, 1'b1, 1'b0);
        exp_q.push_back(8'h0A);
        check("lf_double_state", {30'd0, dbg_state}, 32'd1);
        wait_state("lf_solve", 2'd2, 40);
        tick();
        check("lf_eof_count", eof_cnt - eof_before, 32'd1);
        check("lf_eof_timing", eof_cyc - last_pop_cyc, 32'd1);
        check("lf_ovf", {31'd0, overflow}, 32'd0);
        compare_stream("lf_stream");

        // ir_is_user low: the scan neither pushes nor disturbs shift_reg.
        do_reset();
        inbound_ready = 1'b1;
        write_byte(8'h33, 1'b1, 1'b0);
        exp_q.push_back(8'h33);
        tick();
        tick();
        write_byte(8'h55, 1'b0, 1'b0);
        tick();
        check("ir_no_push", {31'd0, inbound_valid}, 32'd0);
        // A bare update re-pushes the top byte, which is still 0x33.
        update_dr = 1'b1;
        tick();
        update_dr = 1'b0;
        exp_q.push_back(8'h33);
        check("ir_repush_valid", {31'd0, inbound_valid}, 32'd1);
        wait_empty("ir_drain", 10);
        compare_stream("ir_stream");

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
